cache_miss_unit: RTL and testbench

Single-MSHR miss unit directly downstream of the data-cache controller. It accepts one miss or bypass request at a time and drives a 64-bit memory port: a 2-beat line read for cacheable misses, or a single-beat access for bypass requests. During a refill it forwards the critical word to the controller, then writes the assembled 128-bit line into one of 8 ways. It also answers the controller's MSHR address/index match queries.

---
 rtl/cache_miss_unit.sv | 243 ++++++++++++++++++++++++
 tb/tb_cache_miss_unit.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_miss_unit.sv
// cache_miss_unit
// ---------------
// Single-MSHR miss handler sitting below the data-cache controller. One
// request is in flight at a time:
//   * cacheable miss  -> 2-beat line read, critical word forwarded, then
//                        the assembled 128-bit line is written into a
//                        round-robin victim way;
//   * bypass request  -> single-beat uncached read or write.
// The MSHR address/index comparators are combinational so the controller
// can stall hits against the line being refilled.
//
// Handshakes: every request/grant pair follows valid/ready rules. A
// request (miss_valid_i, mem_req_o, refill_req_o) is held stable until the
// matching grant (miss_gnt_o / bypass_gnt_o, mem_gnt_i, refill_gnt_i) is seen
// high in the same cycle; the transfer happens on that clock edge.
// Response pulses (mem_rvalid_i, bypass_valid_o, critical_word_valid_o)
// have no back-pressure.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   miss_*_i                  request from the cache controller
//   miss_gnt_o / bypass_gnt_o grant pulses (cacheable / bypass)
//   bypass_valid_o/data_o     registered bypass response
//   active_serving_o          refill in progress
//   critical_word_*_o         requested word of the refilling line
//   mshr_addr_i, mshr_*_matches_o  MSHR query
//   mem_*                     64-bit memory port
//   refill_*                  cache array line write
//   busy_o                    FSM not idle
module cache_miss_unit #(
  parameter int PLEN        = 34,
  parameter int INDEX_WIDTH = 12,
  parameter int TAG_WIDTH   = PLEN - INDEX_WIDTH,
  parameter int LINE_WIDTH  = 128,
  parameter int SET_ASSOC   = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   miss_valid_i,
  input  logic                   miss_bypass_i,
  input  logic                   miss_we_i,
  input  logic [PLEN-1:0]        miss_addr_i,
  input  logic [63:0]            miss_wdata_i,
  input  logic [7:0]             miss_be_i,
  output logic                   miss_gnt_o,
  output logic                   bypass_gnt_o,
  output logic                   bypass_valid_o,
  output logic [63:0]            bypass_data_o,
  output logic                   active_serving_o,
  output logic [63:0]            critical_word_o,
  output logic                   critical_word_valid_o,
  input  logic [PLEN-1:0]        mshr_addr_i,
  output logic                   mshr_addr_matches_o,
  output logic                   mshr_index_matches_o,
  output logic                   mem_req_o,
  input  logic                   mem_gnt_i,
  output logic [PLEN-1:0]        mem_addr_o,
  output logic                   mem_we_o,
  output logic [63:0]            mem_wdata_o,
  output logic [7:0]             mem_be_o,
  output logic                   mem_burst_o,
  input  logic                   mem_rvalid_i,
  input  logic [63:0]            mem_rdata_i,
  output logic                   refill_req_o,
  input  logic                   refill_gnt_i,
  output logic [INDEX_WIDTH-1:0] refill_index_o,
  output logic [TAG_WIDTH-1:0]   refill_tag_o,
  output logic [LINE_WIDTH-1:0]  refill_data_o,
  output logic [SET_ASSOC-1:0]   refill_way_o,
  output logic                   busy_o
);

  localparam int VW = $clog2(SET_ASSOC);

  typedef enum logic [2:0] {
    IDLE, BYP_REQ, BYP_WAIT, REF_REQ, REF_DATA, REF_WRITE
  } state_e;

  state_e            state_q, state_d;
  logic [PLEN-1:0]   addr_q;
  logic              we_q;
  logic [63:0]       wdata_q;
  logic [7:0]        be_q;
  logic              mshr_valid_q;
  logic              beat_cnt_q;
  logic [63:0]       beat0_q, beat1_q;
  logic [VW-1:0]     victim_q;
  logic              bypass_valid_q;
  logic [63:0]       bypass_data_q;
  logic              crit_valid_q;
  logic [63:0]       crit_word_q;

  // Byte-offset bits of the query address never take part in a match.
  logic unused_query_bits;
  assign unused_query_bits = ^mshr_addr_i[3:0];

  // Next-state and handshake outputs.
  always_comb begin
    state_d      = state_q;
    miss_gnt_o   = 1'b0;
    bypass_gnt_o = 1'b0;
    mem_req_o    = 1'b0;
    mem_addr_o   = '0;
    mem_we_o     = 1'b0;
    mem_wdata_o  = '0;
    mem_be_o     = '0;
    mem_burst_o  = 1'b0;
    refill_req_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (miss_valid_i) begin
          if (miss_bypass_i) begin
            state_d = BYP_REQ;
          end else begin
            miss_gnt_o = 1'b1;
            state_d    = REF_REQ;
          end
        end
      end
      BYP_REQ: begin
        mem_req_o   = 1'b1;
        mem_addr_o  = addr_q;
        mem_we_o    = we_q;
        mem_wdata_o = wdata_q;
        mem_be_o    = be_q;
        if (mem_gnt_i) begin
          bypass_gnt_o = 1'b1;
          state_d      = BYP_WAIT;
        end
      end
      BYP_WAIT: begin
        if (mem_rvalid_i) state_d = IDLE;
      end
      REF_REQ: begin
        mem_req_o   = 1'b1;
        mem_addr_o  = {addr_q[PLEN-1:4], 4'h0};
        mem_be_o    = '1;
        mem_burst_o = 1'b1;
        if (mem_gnt_i) state_d = REF_DATA;
      end
      REF_DATA: begin
        // Second beat closes the burst.
        if (mem_rvalid_i && beat_cnt_q) state_d = REF_WRITE;
      end
      REF_WRITE: begin
        refill_req_o = 1'b1;
        if (refill_gnt_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A reset cycle drops every request immediately.
    if (rst_i) begin
      state_d      = IDLE;
      miss_gnt_o   = 1'b0;
      bypass_gnt_o = 1'b0;
      mem_req_o    = 1'b0;
      refill_req_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      we_q           <= 1'b0;
      wdata_q        <= '0;
      be_q           <= '0;
      mshr_valid_q   <= 1'b0;
      beat_cnt_q     <= 1'b0;
      beat0_q        <= '0;
      beat1_q        <= '0;
      victim_q       <= '0;
      bypass_valid_q <= 1'b0;
      bypass_data_q  <= '0;
      crit_valid_q   <= 1'b0;
      crit_word_q    <= '0;
    end else begin
      state_q        <= state_d;
      bypass_valid_q <= 1'b0;
      crit_valid_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (miss_valid_i) begin
            addr_q       <= miss_addr_i;
            we_q         <= miss_we_i & miss_bypass_i;
            wdata_q      <= miss_wdata_i;
            be_q         <= miss_be_i;
            mshr_valid_q <= ~miss_bypass_i;
          end
        end
        BYP_WAIT: begin
          if (mem_rvalid_i) begin
            bypass_valid_q <= 1'b1;
            // A write only gets an ack; its data bus carries nothing useful.
            bypass_data_q  <= we_q ? 64'h0 : mem_rdata_i;
          end
        end
        REF_REQ: begin
          if (mem_gnt_i) beat_cnt_q <= 1'b0;
        end
        REF_DATA: begin
          if (mem_rvalid_i) begin
            if (beat_cnt_q) beat1_q <= mem_rdata_i;
            else            beat0_q <= mem_rdata_i;
            beat_cnt_q <= ~beat_cnt_q;
            // addr[3] selects which 64-bit half the controller asked for.
            if (beat_cnt_q == addr_q[3]) begin
              crit_valid_q <= 1'b1;
              crit_word_q  <= mem_rdata_i;
            end
          end
        end
        REF_WRITE: begin
          if (refill_gnt_i) begin
            victim_q     <= victim_q + 1'b1;
            mshr_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o                = (state_q != IDLE);
  assign active_serving_o      = (state_q == REF_REQ) || (state_q == REF_DATA) ||
                                 (state_q == REF_WRITE);
  assign bypass_valid_o        = bypass_valid_q;
  assign bypass_data_o         = bypass_data_q;
  assign critical_word_valid_o = crit_valid_q;
  assign critical_word_o       = crit_word_q;

  assign refill_index_o = {addr_q[INDEX_WIDTH-1:4], 4'h0};
  assign refill_tag_o   = addr_q[PLEN-1:INDEX_WIDTH];
  assign refill_data_o  = {beat1_q, beat0_q};
  assign refill_way_o   = (state_q == REF_WRITE) ?
                          ({{(SET_ASSOC-1){1'b0}}, 1'b1} << victim_q) : '0;

  assign mshr_addr_matches_o  = mshr_valid_q &&
                                (mshr_addr_i[PLEN-1:4] == addr_q[PLEN-1:4]);
  assign mshr_index_matches_o = mshr_valid_q &&
                                (mshr_addr_i[INDEX_WIDTH-1:4] == addr_q[INDEX_WIDTH-1:4]);

endmodule

// File: tb/tb_cache_miss_unit.sv
// Bench for cache_miss_unit: driver tasks play requester and memory, a
// monitor pops expected responses from queues whenever the DUT presents one.
module tb_cache_miss_unit;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  logic rst_i;

  logic         miss_valid_i, miss_bypass_i, miss_we_i;
  logic [33:0]  miss_addr_i;
  logic [63:0]  miss_wdata_i;
  logic [7:0]   miss_be_i;
  logic         miss_gnt_o, bypass_gnt_o, bypass_valid_o;
  logic [63:0]  bypass_data_o;
  logic         active_serving_o;
  logic [63:0]  critical_word_o;
  logic         critical_word_valid_o;
  logic [33:0]  mshr_addr_i;
  logic         mshr_addr_matches_o, mshr_index_matches_o;
  logic         mem_req_o, mem_gnt_i;
  logic [33:0]  mem_addr_o;
  logic         mem_we_o;
  logic [63:0]  mem_wdata_o;
  logic [7:0]   mem_be_o;
  logic         mem_burst_o, mem_rvalid_i;
  logic [63:0]  mem_rdata_i;
  logic         refill_req_o, refill_gnt_i;
  logic [11:0]  refill_index_o;
  logic [21:0]  refill_tag_o;
  logic [127:0] refill_data_o;
  logic [7:0]   refill_way_o;
  logic         busy_o;

  cache_miss_unit dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .miss_valid_i(miss_valid_i), .miss_bypass_i(miss_bypass_i), .miss_we_i(miss_we_i),
    .miss_addr_i(miss_addr_i), .miss_wdata_i(miss_wdata_i), .miss_be_i(miss_be_i),
    .miss_gnt_o(miss_gnt_o), .bypass_gnt_o(bypass_gnt_o),
    .bypass_valid_o(bypass_valid_o), .bypass_data_o(bypass_data_o),
    .active_serving_o(active_serving_o),
    .critical_word_o(critical_word_o), .critical_word_valid_o(critical_word_valid_o),
    .mshr_addr_i(mshr_addr_i), .mshr_addr_matches_o(mshr_addr_matches_o),
    .mshr_index_matches_o(mshr_index_matches_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_burst_o(mem_burst_o), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .refill_req_o(refill_req_o), .refill_gnt_i(refill_gnt_i),
    .refill_index_o(refill_index_o), .refill_tag_o(refill_tag_o),
    .refill_data_o(refill_data_o), .refill_way_o(refill_way_o),
    .busy_o(busy_o)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [33:0] addr;
    logic        we;
    logic [63:0] wdata;
    logic [7:0]  be;
    logic        burst;
  } memreq_t;

  typedef struct packed {
    logic [21:0]  tag;
    logic [11:0]  index;
    logic [127:0] data;
    logic [7:0]   way;
  } refill_t;

  memreq_t     exp_mem_q[$];
  logic [63:0] exp_crit_q[$];
  logic [63:0] exp_byp_q[$];
  refill_t     exp_ref_q[$];

  int checks = 0;
  int errors = 0;
  int victim_model = 0;  // refills completed since reset, modulo 8

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Monitor: compares at the falling edge, away from the active edge.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (mem_req_o && mem_gnt_i) begin
        if (exp_mem_q.size() == 0) fail("unexpected mem request");
        else begin
          memreq_t e;
          e = exp_mem_q.pop_front();
          check("mem_addr_o", mem_addr_o, e.addr);
          check("mem_we_o", mem_we_o, e.we);
          check("mem_be_o", mem_be_o, e.be);
          check("mem_burst_o", mem_burst_o, e.burst);
          if (!e.burst) check("mem_wdata_o", mem_wdata_o, e.wdata);
        end
      end
      if (critical_word_valid_o) begin
        if (exp_crit_q.size() == 0) fail("unexpected critical_word_valid_o");
        else check("critical_word_o", critical_word_o, exp_crit_q.pop_front());
      end
      if (bypass_valid_o) begin
        if (exp_byp_q.size() == 0) fail("unexpected bypass_valid_o");
        else check("bypass_data_o", bypass_data_o, exp_byp_q.pop_front());
      end
      if (refill_req_o) begin
        if (exp_ref_q.size() == 0) fail("unexpected refill_req_o");
        else if (refill_gnt_i) begin
          refill_t r;
          r = exp_ref_q.pop_front();
          check("refill_tag_o", refill_tag_o, r.tag);
          check("refill_index_o", refill_index_o, r.index);
          check("refill_data_o", refill_data_o, r.data);
          check("refill_way_o", refill_way_o, r.way);
        end
      end
      if (miss_valid_i && busy_o) check("miss_gnt_o while busy", miss_gnt_o, 1'b0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // which: 0 = mem_req_o, 1 = miss_gnt_o, 2 = refill_req_o
  task automatic wait_sig(input int which, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      case (which)
        0:       hit = mem_req_o;
        1:       hit = miss_gnt_o;
        default: hit = refill_req_o;
      endcase
      if (hit) break;
      tick();
    end
    if (!hit) fail({name, " timeout"});
  endtask

  task automatic query(input logic [33:0] q, input logic [33:0] line_addr, input bit valid);
    bit am, im;
    am = valid && ((q >> 4) == (line_addr >> 4));
    im = valid && (((q >> 4) % 256) == ((line_addr >> 4) % 256));
    mshr_addr_i = q;
    @(negedge clk_i);
    check("mshr_addr_matches_o", mshr_addr_matches_o, am);
    check("mshr_index_matches_o", mshr_index_matches_o, im);
    tick();
  endtask

  task automatic do_miss(input logic [33:0] addr, input logic [63:0] b0, input logic [63:0] b1);
    logic [33:0] line;
    line = (addr >> 4) << 4;
    exp_mem_q.push_back('{addr: line, we: 1'b0, wdata: 64'h0, be: 8'hFF, burst: 1'b1});
    exp_crit_q.push_back(addr[3] ? b1 : b0);
    exp_ref_q.push_back('{tag: addr[33:12], index: {addr[11:4], 4'h0},
                          data: {b1, b0}, way: 8'(1 << victim_model)});
    victim_model = (victim_model + 1) % 8;

    miss_valid_i  = 1'b1;
    miss_bypass_i = 1'b0;
    miss_we_i     = 1'($urandom);
    miss_addr_i   = addr;
    wait_sig(1, "miss_gnt_o");
    tick();
    miss_valid_i = 1'b0;

    wait_sig(0, "refill mem_req_o");
    tick();
    repeat ($urandom_range(0, 3)) tick();
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;

    // Refill in progress: probe the MSHR and try a competing request.
    @(negedge clk_i);
    check("active_serving_o", active_serving_o, 1'b1);
    tick();
    query(addr, addr, 1'b1);
    query(addr ^ 34'h4000, addr, 1'b1);
    query(34'({$urandom, $urandom}), addr, 1'b1);
    miss_valid_i  = 1'b1;
    miss_bypass_i = 1'($urandom);
    miss_addr_i   = 34'({$urandom, $urandom});

    mem_rvalid_i = 1'b1;
    mem_rdata_i  = b0;
    tick();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 64'($urandom);
    repeat ($urandom_range(0, 2)) tick();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = b1;
    tick();
    mem_rvalid_i = 1'b0;

    wait_sig(2, "refill_req_o");
    tick();
    miss_valid_i = 1'b0;
    repeat ($urandom_range(0, 2)) tick();
    refill_gnt_i = 1'b1;
    tick();
    refill_gnt_i = 1'b0;
    query(addr, addr, 1'b0);
  endtask

  task automatic do_bypass(input logic [33:0] addr, input logic we, input logic [63:0] wdata,
                           input logic [7:0] be, input logic [63:0] rdata, input int stall);
    exp_mem_q.push_back('{addr: addr, we: we, wdata: wdata, be: be, burst: 1'b0});
    exp_byp_q.push_back(we ? 64'h0 : rdata);
    miss_valid_i  = 1'b1;
    miss_bypass_i = 1'b1;
    miss_we_i     = we;
    miss_addr_i   = addr;
    miss_wdata_i  = wdata;
    miss_be_i     = be;
    wait_sig(0, "bypass mem_req_o");
    tick();
    repeat (stall) tick();
    mem_gnt_i = 1'b1;
    @(negedge clk_i);
    check("bypass_gnt_o on grant", bypass_gnt_o, 1'b1);
    tick();
    mem_gnt_i    = 1'b0;
    miss_valid_i = 1'b0;
    @(negedge clk_i);
    check("bypass_gnt_o single pulse", bypass_gnt_o, 1'b0);
    tick();
    repeat ($urandom_range(0, 2)) tick();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = rdata;
    tick();
    mem_rvalid_i = 1'b0;
    @(negedge clk_i);
    check("bypass_valid_o after rvalid", bypass_valid_o, 1'b1);
    check("no refill_req_o on bypass", refill_req_o, 1'b0);
    tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_i = 1'b1;
    miss_valid_i = 1'b0; miss_bypass_i = 1'b0; miss_we_i = 1'b0;
    miss_addr_i = '0; miss_wdata_i = '0; miss_be_i = '0;
    mshr_addr_i = '0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    refill_gnt_i = 1'b0;
    repeat (3) tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("reset busy_o", busy_o, 1'b0);
    check("reset mem_req_o", mem_req_o, 1'b0);
    check("reset refill_req_o", refill_req_o, 1'b0);
    check("reset active_serving_o", active_serving_o, 1'b0);
    check("reset bypass_valid_o", bypass_valid_o, 1'b0);
    check("reset critical_word_valid_o", critical_word_valid_o, 1'b0);
    check("reset mshr_addr_matches_o", mshr_addr_matches_o, 1'b0);
    check("reset refill_way_o", refill_way_o, 8'h00);
    check("reset mem_addr_o", mem_addr_o, 34'h0);
    tick();

    // Directed cases.
    do_miss(34'h0_0000_1238, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222);
    do_bypass(34'h2_0000_0010, 1'b0, 64'h0, 8'hFF, 64'h0000_0000_DEAD_BEEF, 3);
    do_bypass(34'h0_0000_0400, 1'b1, 64'hA5A5, 8'h0F, 64'h1234_5678_9ABC_DEF0, 0);

    // Nine refills in a row: the victim way walks round and wraps.
    for (int i = 0; i < 9; i++)
      do_miss(34'({$urandom, $urandom}), {$urandom, $urandom}, {$urandom, $urandom});

    // Reset in the middle of a refill, after the first beat.
    begin
      logic [33:0] a;
      a = 34'({$urandom, $urandom}) | 34'h8;  // critical word is beat 1
      exp_mem_q.push_back('{addr: (a >> 4) << 4, we: 1'b0, wdata: 64'h0, be: 8'hFF, burst: 1'b1});
      miss_valid_i = 1'b1; miss_bypass_i = 1'b0; miss_addr_i = a;
      wait_sig(1, "miss_gnt_o before reset");
      tick();
      miss_valid_i = 1'b0;
      wait_sig(0, "mem_req_o before reset");
      tick();
      mem_gnt_i = 1'b1;
      tick();
      mem_gnt_i = 1'b0;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = {$urandom, $urandom};
      tick();
      mem_rvalid_i = 1'b0;
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      victim_model = 0;
      mshr_addr_i = a;
      @(negedge clk_i);
      check("post-reset busy_o", busy_o, 1'b0);
      check("post-reset refill_req_o", refill_req_o, 1'b0);
      check("post-reset active_serving_o", active_serving_o, 1'b0);
      check("post-reset mshr_addr_matches_o", mshr_addr_matches_o, 1'b0);
      check("post-reset mshr_index_matches_o", mshr_index_matches_o, 1'b0);
      tick();
      repeat (4) tick();
    end

    // Randomised mix, with stray rvalid pulses while idle.
    for (int i = 0; i < 24; i++) begin
      int kind;
      kind = $urandom_range(0, 3);
      if (kind == 0)
        do_bypass(34'({$urandom, $urandom}), 1'b0, {$urandom, $urandom}, 8'($urandom),
                  {$urandom, $urandom}, $urandom_range(0, 3));
      else if (kind == 1)
        do_bypass(34'({$urandom, $urandom}), 1'b1, {$urandom, $urandom}, 8'($urandom),
                  {$urandom, $urandom}, $urandom_range(0, 3));
      else
        do_miss(34'({$urandom, $urandom}), {$urandom, $urandom}, {$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = {$urandom, $urandom};
        tick();
        mem_rvalid_i = 1'b0;
        tick();
      end
    end

    repeat (5) tick();
    check("leftover mem requests", exp_mem_q.size(), 0);
    check("leftover critical words", exp_crit_q.size(), 0);
    check("leftover bypass responses", exp_byp_q.size(), 0);
    check("leftover refills", exp_ref_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
